// File: rtl/twobit_pht_ctrl_pkg.sv
// Shared types and helpers for the 2-bit saturating-counter PHT controller.
//   ctr_t      : 2-bit predictor counter, MSB is the predicted direction
//   state_t    : update sequencer states
//   ctr_next() : saturating counter step toward the actual outcome
package twobit_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT   = 2'd0;
   localparam ctr_t CTR_WNT   = 2'd1;
   localparam ctr_t CTR_WT    = 2'd2;
   localparam ctr_t CTR_ST    = 2'd3;
   localparam ctr_t CTR_RESET = CTR_WNT;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPD_RD = 2'd1,
      UPD_WR = 2'd2
   } state_t;

   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      if (taken) return (c == CTR_ST)  ? c : c + 2'd1;
      else       return (c == CTR_SNT) ? c : c - 2'd1;
   endfunction

endpackage

// File: rtl/twobit_pht_ctrl_if.sv
// Lookup / prediction / resolve handshake bundle of the PHT controller.
//   master : trace front end (drives lk_*, res_valid/res_taken)
//   slave  : twobit_pht_ctrl
interface twobit_pht_ctrl_if
   import twobit_pkg::*;
#(
   parameter int BR_W = 2
);
   logic            lk_valid;
   logic [BR_W-1:0] lk_branch;
   logic            lk_ready;
   logic            pred_valid;
   logic            pred_taken;
   ctr_t            pred_state;
   logic            res_valid;
   logic            res_taken;
   logic            res_ready;

   modport master (
      output lk_valid, lk_branch, res_valid, res_taken,
      input  lk_ready, pred_valid, pred_taken, pred_state, res_ready
   );

   modport slave (
      input  lk_valid, lk_branch, res_valid, res_taken,
      output lk_ready, pred_valid, pred_taken, pred_state, res_ready
   );
endinterface

// File: rtl/twobit_pht_ctrl_fifo.sv
// twobit_inflight_fifo: in-order store of in-flight predictions.
//   clk, reset : clock, async active-low reset
//   push/din   : append entry (ignored when full)
//   pop        : drop head entry (ignored when empty)
//   flush      : drop every entry, wins over push/pop
//   dout       : head entry
//   count      : entries held; full / empty flags
module twobit_inflight_fifo #(
   parameter int W     = 3,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [W-1:0]              din,
   input  logic                      pop,
   input  logic                      flush,
   output logic [W-1:0]              dout,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // payload needs no reset: it is only observed while count says it is valid
   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= din;

   // DEPTH is a power of two, so the pointers wrap by plain overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end
endmodule

// File: rtl/twobit_pht_ctrl.sv
// twobit_pht_ctrl: 2-bit saturating predictor table with one access port
// shared by prediction lookups and 3-cycle resolve updates.
//   clk, reset  : clock, async active-low reset
//   pht_bus     : lookup / prediction / resolve handshakes (slave side)
//   flush       : drop all in-flight predictions (table kept)
//   inflight    : in-flight prediction count
//   miss_count  : saturating misprediction count
//   err_orphan  : pulse after a resolve request with nothing in flight
module twobit_pht_ctrl
   import twobit_pkg::*;
#(
   parameter int BR_W       = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int MISS_W     = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   twobit_pht_ctrl_if.slave             pht_bus,
   input  logic                         flush,
   output logic [$clog2(FIFO_DEPTH):0]  inflight,
   output logic [MISS_W-1:0]            miss_count,
   output logic                         err_orphan
);
   localparam int NUM_ENT = 1 << BR_W;

   state_t          state, state_nxt;
   ctr_t            pht [NUM_ENT];
   ctr_t            rd_ctr, lk_ctr, pred_state_q;
   logic            taken_q, flush_pend;
   logic            pred_valid_q, pred_taken_q;
   logic            lk_fire, res_fire;
   logic            fifo_full, fifo_empty, fifo_pop, fifo_flush;
   logic [BR_W:0]   head;
   logic [BR_W-1:0] head_br;
   logic            head_pred;

   assign lk_ctr    = pht[pht_bus.lk_branch];
   assign head_br   = head[BR_W:1];
   assign head_pred = head[0];

   // resolve wins the port; a lookup never fires in a resolve accept cycle
   assign pht_bus.res_ready = (state == IDLE) && !fifo_empty && !flush;
   assign res_fire          = pht_bus.res_valid && pht_bus.res_ready;
   assign pht_bus.lk_ready  = (state == IDLE) && !fifo_full && !flush && !res_fire;
   assign lk_fire           = pht_bus.lk_valid && pht_bus.lk_ready;

   assign pht_bus.pred_valid = pred_valid_q;
   assign pht_bus.pred_taken = pred_taken_q;
   assign pht_bus.pred_state = pred_state_q;

   always_comb begin
      state_nxt  = state;
      fifo_pop   = 1'b0;
      // a flush seen mid-update lets the head update finish, then drops the rest
      fifo_flush = (state == IDLE) && flush;
      case (state)
         IDLE:    if (res_fire) state_nxt = UPD_RD;
         UPD_RD:  state_nxt = UPD_WR;
         UPD_WR: begin
            state_nxt  = IDLE;
            fifo_pop   = 1'b1;
            fifo_flush = flush || flush_pend;
         end
         default: state_nxt = IDLE;
      endcase
   end

   twobit_inflight_fifo #(.W(BR_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (lk_fire),
      .din   ({pht_bus.lk_branch, lk_ctr[1]}),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .dout  (head),
      .count (inflight),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         flush_pend   <= 1'b0;
         taken_q      <= 1'b0;
         rd_ctr       <= CTR_RESET;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_state_q <= CTR_SNT;
         miss_count   <= '0;
         err_orphan   <= 1'b0;
      end else begin
         state        <= state_nxt;
         pred_valid_q <= lk_fire;
         err_orphan   <= pht_bus.res_valid && fifo_empty;
         if (lk_fire) begin
            pred_state_q <= lk_ctr;
            pred_taken_q <= lk_ctr[1];
         end
         if (res_fire) taken_q <= pht_bus.res_taken;
         if (state == UPD_RD) rd_ctr <= pht[head_br];
         if (state == UPD_WR)             flush_pend <= 1'b0;
         else if (flush && state != IDLE) flush_pend <= 1'b1;
         if (state == UPD_WR && taken_q != head_pred && miss_count != '1)
            miss_count <= miss_count + MISS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ENT; i++) pht[i] <= CTR_RESET;
      end else if (state == UPD_WR) begin
         pht[head_br] <= ctr_next(rd_ctr, taken_q);
      end
   end
endmodule

// File: tb/tb_twobit_pht_ctrl.sv
module tb_twobit_pht_ctrl;
   import twobit_pkg::*;

   localparam int BR_W = 2, DEPTH = 4, MISS_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic [2:0]        inflight;
   logic [MISS_W-1:0] miss_count;
   logic              err_orphan;

   twobit_pht_ctrl_if #(.BR_W(BR_W)) bus_if ();

   twobit_pht_ctrl #(.BR_W(BR_W), .FIFO_DEPTH(DEPTH), .MISS_W(MISS_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .pht_bus    (bus_if.slave),
      .flush      (flush),
      .inflight   (inflight),
      .miss_count (miss_count),
      .err_orphan (err_orphan)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: counter values per branch, queue of {branch, predicted bit}
   int m_pht [4];
   int m_q [$];
   int m_miss;

   task automatic model_reset();
      foreach (m_pht[i]) m_pht[i] = 1;
      m_q.delete();
      m_miss = 0;
   endtask

   task automatic model_resolve(input bit t);
      int e, b, p;
      e = m_q.pop_front();
      b = e / 2;
      p = e % 2;
      if (int'(t) != p) m_miss++;
      if (t) m_pht[b] = (m_pht[b] >= 3) ? 3 : m_pht[b] + 1;
      else   m_pht[b] = (m_pht[b] <= 0) ? 0 : m_pht[b] - 1;
   endtask

   // issue one lookup, wait for acceptance, compare the prediction
   task automatic do_lookup(input int b, input string tag);
      bit ok = 0;
      logic [1:0] bb;
      bb = b[1:0];
      bus_if.lk_valid  = 1'b1;
      bus_if.lk_branch = bb;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_if.lk_ready) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s lk_ready timeout: lk_ready=%0b want 1", tag, bus_if.lk_ready);
         bus_if.lk_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus_if.lk_valid = 1'b0;
      if (bus_if.pred_valid !== 1'b1 || bus_if.pred_state !== 2'(m_pht[b]) ||
          bus_if.pred_taken !== (m_pht[b] >= 2)) begin
         errors++;
         $display("FAIL %s pred b=%0d: got v=%0b st=%0d t=%0b want v=1 st=%0d t=%0b",
                  tag, b, bus_if.pred_valid, bus_if.pred_state, bus_if.pred_taken,
                  m_pht[b], (m_pht[b] >= 2));
      end
      m_q.push_back(b * 2 + ((m_pht[b] >= 2) ? 1 : 0));
   endtask

   // issue one resolve, wait for the update to finish, compare counters
   task automatic do_resolve(input bit t, input string tag);
      bit ok = 0;
      bus_if.res_valid = 1'b1;
      bus_if.res_taken = t;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_if.res_ready) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s res_ready timeout: res_ready=%0b want 1", tag, bus_if.res_ready);
         bus_if.res_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus_if.res_valid = 1'b0;
      bus_if.res_taken = ~t;       // must be ignored after accept
      model_resolve(t);
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (miss_count !== 32'(m_miss) || inflight !== 3'(m_q.size())) begin
         errors++;
         $display("FAIL %s resolve: miss=%0d inflight=%0d want miss=%0d inflight=%0d",
                  tag, miss_count, inflight, m_miss, m_q.size());
      end
   endtask

   task automatic drain();
      while (m_q.size() > 0) do_resolve(1'($urandom_range(0, 1)), "drain");
   endtask

   // lookup held against a simultaneous resolve; count the stalled cycles
   task automatic contended_lookup(input int b, input string tag);
      int stall = 1;
      bit t;
      logic [1:0] bb;
      bb = b[1:0];
      t = 1'($urandom_range(0, 1));
      bus_if.lk_valid  = 1'b1;
      bus_if.lk_branch = bb;
      bus_if.res_valid = 1'b1;
      bus_if.res_taken = t;
      @(negedge clk);
      checks++;
      if (bus_if.res_ready !== 1'b1 || bus_if.lk_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s priority: res_ready=%0b lk_ready=%0b want 1 0",
                  tag, bus_if.res_ready, bus_if.lk_ready);
      end
      @(posedge clk); #1;
      bus_if.res_valid = 1'b0;
      model_resolve(t);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_if.lk_ready) break;
         stall++;
      end
      checks++;
      if (stall != 3) begin
         errors++;
         $display("FAIL %s stall cycles: got %0d want 3", tag, stall);
      end
      @(posedge clk); #1;
      bus_if.lk_valid = 1'b0;
      checks++;
      if (bus_if.pred_valid !== 1'b1 || bus_if.pred_state !== 2'(m_pht[b])) begin
         errors++;
         $display("FAIL %s stalled pred: v=%0b st=%0d want v=1 st=%0d",
                  tag, bus_if.pred_valid, bus_if.pred_state, m_pht[b]);
      end
      m_q.push_back(b * 2 + ((m_pht[b] >= 2) ? 1 : 0));
   endtask

   task automatic test_reset();
      reset = 1'b0;
      flush = 1'b0;
      bus_if.lk_valid = 1'b0; bus_if.lk_branch = '0;
      bus_if.res_valid = 1'b0; bus_if.res_taken = 1'b0;
      #12;
      checks++;
      if (bus_if.lk_ready !== 1'b1 || bus_if.res_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset ready: lk=%0b res=%0b want 1 0", bus_if.lk_ready, bus_if.res_ready);
      end
      checks++;
      if (bus_if.pred_valid !== 1'b0 || bus_if.pred_taken !== 1'b0 || bus_if.pred_state !== 2'd0 ||
          inflight !== 3'd0 || miss_count !== 32'd0 || err_orphan !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: pv=%0b pt=%0b ps=%0d inf=%0d miss=%0d orph=%0b want all 0",
                  bus_if.pred_valid, bus_if.pred_taken, bus_if.pred_state, inflight, miss_count, err_orphan);
      end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_lookup_basic();
      do_lookup(2, "first_lookup");
      checks++;
      if (bus_if.pred_state !== CTR_WNT || bus_if.pred_taken !== 1'b0 || inflight !== 3'd1) begin
         errors++;
         $display("FAIL first_lookup const: st=%0d t=%0b inf=%0d want 1 0 1",
                  bus_if.pred_state, bus_if.pred_taken, inflight);
      end
   endtask

   task automatic test_train();
      do_resolve(1'b1, "train1");
      do_lookup(2, "train_lk2");
      do_resolve(1'b1, "train2");
      do_lookup(2, "train_lk3");
      do_resolve(1'b1, "train3");
      do_lookup(2, "train_lk4");
      checks++;
      if (bus_if.pred_state !== CTR_ST || miss_count !== 32'd1) begin
         errors++;
         $display("FAIL train saturate: st=%0d miss=%0d want 3 1", bus_if.pred_state, miss_count);
      end
      drain();
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) do_lookup(int'($urandom_range(0, 3)), "fill");
      bus_if.lk_valid  = 1'b1;
      bus_if.lk_branch = 2'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus_if.lk_ready !== 1'b0 || inflight !== 3'd4) begin
            errors++;
            $display("FAIL full hold: lk_ready=%0b inflight=%0d want 0 4", bus_if.lk_ready, inflight);
         end
      end
      @(posedge clk); #1;
      contended_lookup(3, "full_resolve");
      checks++;
      if (inflight !== 3'd4) begin
         errors++;
         $display("FAIL full refill: inflight=%0d want 4", inflight);
      end
      drain();
   endtask

   task automatic test_back_to_back_priority();
      do_lookup(int'($urandom_range(0, 3)), "prio_setup");
      contended_lookup(int'($urandom_range(0, 3)), "prio");
      drain();
   endtask

   task automatic test_orphan_flush();
      bit seen;
      bus_if.res_valid = 1'b1;
      bus_if.res_taken = 1'b1;
      @(negedge clk);
      seen = err_orphan;
      checks++;
      if (bus_if.res_ready !== 1'b0) begin
         errors++;
         $display("FAIL orphan res_ready: got %0b want 0", bus_if.res_ready);
      end
      @(posedge clk); #1;
      bus_if.res_valid = 1'b0;
      seen = seen | err_orphan;
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL orphan pulse: got %0b want 1", seen);
      end
      @(posedge clk); #1;
      checks++;
      if (err_orphan !== 1'b0 || inflight !== 3'd0 || miss_count !== 32'(m_miss)) begin
         errors++;
         $display("FAIL orphan after: orph=%0b inf=%0d miss=%0d want 0 0 %0d",
                  err_orphan, inflight, miss_count, m_miss);
      end
      for (int b = 0; b < 3; b++) do_lookup(b, "orphan_pht");
      flush = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.lk_ready !== 1'b0 || bus_if.res_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush ready: lk=%0b res=%0b want 0 0", bus_if.lk_ready, bus_if.res_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      m_q.delete();
      checks++;
      if (inflight !== 3'd0) begin
         errors++;
         $display("FAIL flush idle: inflight=%0d want 0", inflight);
      end
   endtask

   task automatic test_flush_mid_update();
      bit t;
      int b0;
      b0 = int'($urandom_range(0, 3));
      t  = 1'($urandom_range(0, 1));
      do_lookup(b0, "fmu_fill");
      do_lookup(int'($urandom_range(0, 3)), "fmu_fill");
      do_lookup(int'($urandom_range(0, 3)), "fmu_fill");
      bus_if.res_valid = 1'b1;
      bus_if.res_taken = t;
      @(negedge clk);
      @(posedge clk); #1;
      bus_if.res_valid = 1'b0;
      flush = 1'b1;                 // arrives during UPD_RD
      model_resolve(t);
      @(posedge clk); #1;
      flush = 1'b0;
      @(posedge clk); #1;
      m_q.delete();
      checks++;
      if (inflight !== 3'd0 || miss_count !== 32'(m_miss)) begin
         errors++;
         $display("FAIL flush mid update: inf=%0d miss=%0d want 0 %0d", inflight, miss_count, m_miss);
      end
      do_lookup(b0, "fmu_pht");
      drain();
   endtask

   task automatic test_random();
      for (int n = 0; n < 150; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 5 && m_q.size() < DEPTH) begin
            do_lookup(int'($urandom_range(0, 3)), "rand_lk");
         end else if (r < 9 && m_q.size() > 0) begin
            do_resolve(1'($urandom_range(0, 1)), "rand_res");
         end else if (r == 9) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            m_q.delete();
            checks++;
            if (inflight !== 3'd0) begin
               errors++;
               $display("FAIL rand_flush: inflight=%0d want 0", inflight);
            end
         end else if (m_q.size() < DEPTH) begin
            do_lookup(int'($urandom_range(0, 3)), "rand_lk2");
         end
      end
      drain();
   endtask

   task automatic test_reset_mid_update();
      do_lookup(1, "rmu_setup");
      bus_if.res_valid = 1'b1;
      bus_if.res_taken = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus_if.res_valid = 1'b0;
      reset = 1'b0;                 // in UPD_RD
      #2;
      checks++;
      if (bus_if.lk_ready !== 1'b1 || bus_if.pred_valid !== 1'b0 || inflight !== 3'd0 ||
          miss_count !== 32'd0) begin
         errors++;
         $display("FAIL reset mid: lk=%0b pv=%0b inf=%0d miss=%0d want 1 0 0 0",
                  bus_if.lk_ready, bus_if.pred_valid, inflight, miss_count);
      end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
         do_lookup(b, "rmu_pht");
         checks++;
         if (bus_if.pred_state !== CTR_RESET) begin
            errors++;
            $display("FAIL rmu_pht_const b=%0d: st=%0d want 1", b, bus_if.pred_state);
         end
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_lookup_basic();
      test_train();
      test_full();
      test_back_to_back_priority();
      test_orphan_flush();
      test_flush_mid_update();
      test_random();
      test_reset_mid_update();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end
endmodule
